dot_product_engine: RTL
=======================

DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 SHALL have parameter SIZE, default 8: number of elements per packed vector.
REQ-002 SHALL have parameter BITi, default 16: signed element width.
REQ-003 SHALL have parameter BITo, default 128: packed vector width, equal to SIZE*BITi.
REQ-004 SHALL have parameter BITa, default 2*BITi+$clog2(SIZE) (35): signed accumulator and result width.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port d, input, BITo bits: packed signed activations, element i at [BITi*(i+1)-1 : BITi*i].
REQ-008 SHALL have port w, input, BITo bits: packed signed weights, same packing as d.
REQ-009 SHALL have port threshold, input, BITa-1 bits: unsigned early-termination bound.
REQ-010 SHALL have port et_en, input, 1 bit: early-termination enable.
REQ-011 SHALL have port in_valid, input, 1 bit: d, w, threshold and et_en are valid.
REQ-012 SHALL have port in_ready, output, 1 bit: the engine accepts a new vector pair.
REQ-013 SHALL have port q, output, BITa bits: result after ReLU, signed, never negative.
REQ-014 SHALL have port early, output, 1 bit: result was produced by early termination.
REQ-015 SHALL have port count, output, $clog2(SIZE)+1 bits: number of products accumulated.
REQ-016 SHALL have port out_valid, output, 1 bit: q, early and count are valid.
REQ-017 SHALL have port out_ready, input, 1 bit: the consumer takes the result.

Function
REQ-018 SHALL implement FSM states IDLE, MAC and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-020 SHALL, on IDLE with in_valid=1, latch d, w, threshold and et_en, clear acc and idx, and go to MAC.
REQ-021 SHALL, in each MAC cycle, compute new_acc = acc + d[idx]*w[idx] (full-precision signed product, sign-extended to BITa, no overflow possible), store it, and increment idx.
REQ-022 SHALL go to DONE with early=0 and count=SIZE when idx==SIZE-1 in MAC.
REQ-023 SHALL, when idx<SIZE-1, et_en=1 and new_acc < -threshold (signed compare), go to DONE with early=1 and count=idx+1.
REQ-024 SHALL give priority to the last-element rule (REQ-022) when REQ-022 and REQ-023 hold in the same cycle, so that early=0.
REQ-025 SHALL register q = (final acc > 0) ? acc : 0 when entering DONE.
REQ-026 SHALL have latency of SIZE edges from the accept edge to out_valid for a full run, and k edges for termination after k products.
REQ-027 SHALL hold q, early, count and out_valid stable in DONE while out_ready=0.
REQ-028 SHALL return to IDLE on the edge where out_ready=1 in DONE, so that throughput is at most one vector per SIZE+2 cycles.
REQ-029 SHALL ignore in_valid outside IDLE; latched inputs SHALL not change during MAC.

Reset
REQ-030 SHALL, while reset=0 (asynchronously), force state=IDLE, acc=0, idx=0, q=0, early=0, count=0, out_valid=0 and in_ready=1, including when reset asserts mid-MAC or in DONE.
REQ-031 SHALL not produce a partial result after reset deasserts; the next accept SHALL start a fresh run.

Structure
REQ-032 SHALL take the ON/OFF constants and the IDLE/MAC/DONE state encodings from the shared definitions include.
REQ-033 SHALL contain one sub-module, mac_unit, that is a combinational signed multiply-accumulate (acc, a, b -> new_acc) parameterised by BITi and BITa.

Verification
REQ-034 SHALL verify: all d=1, w=2, et_en=0 -> q=16, early=0, count=8, out_valid 8 edges after accept.
REQ-035 SHALL verify: d0=-100, w0=100, remaining d=w=1, threshold=5000, et_en=1 -> early=1, count=1, q=0, out_valid 1 edge after accept.
REQ-036 SHALL verify: the same vectors as REQ-035 with et_en=0 -> acc=-9993, q=0, early=0, count=8.
REQ-037 SHALL verify: all d=w=-32768 -> q=8589934592 (2^33), no overflow.
REQ-038 SHALL verify: out_ready held 0 for 3 cycles in DONE -> outputs constant, in_ready=0; accept of the next vector 1 edge after out_ready=1.
REQ-039 SHALL verify: reset pulsed at idx=4 -> immediate IDLE, all outputs at reset values, and the next vector produces the correct full result.

Source files
------------

// File: rtl/dot_product_engine_pkg.sv
// rtl/dot_product_engine_pkg.sv - shared constants and FSM state encoding for the dot product engine
package dot_product_engine_pkg;

   localparam logic ON  = 1'b1;
   localparam logic OFF = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/dot_product_engine_mac_unit.sv
// rtl/dot_product_engine_mac_unit.sv - combinational signed multiply-accumulate
module mac_unit #(
   parameter int BITi = 16,
   parameter int BITa = 35
) (
   input  logic signed [BITa-1:0] acc,
   input  logic signed [BITi-1:0] a,
   input  logic signed [BITi-1:0] b,
   output logic signed [BITa-1:0] new_acc
);

   logic signed [2*BITi-1:0] prod;

   // Full-precision product, sign-extended into the accumulator width.
   assign prod    = a * b;
   assign new_acc = acc + BITa'(prod);

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - one-product-per-cycle signed dot product with early termination and ReLU
module dot_product_engine
   import dot_product_engine_pkg::*;
#(
   parameter int SIZE = 8,
   parameter int BITi = 16,
   parameter int BITo = SIZE * BITi,
   parameter int BITa = 2 * BITi + $clog2(SIZE)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [BITo-1:0]           d,
   input  logic [BITo-1:0]           w,
   input  logic [BITa-2:0]           threshold,
   input  logic                      et_en,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic signed [BITa-1:0]    q,
   output logic                      early,
   output logic [$clog2(SIZE):0]     count,
   output logic                      out_valid,
   input  logic                      out_ready
);

   localparam int IW = $clog2(SIZE);
   localparam int CW = IW + 1;

   state_t                 state;
   state_t                 next_state;
   logic [BITo-1:0]        d_lat;
   logic [BITo-1:0]        w_lat;
   logic [BITa-2:0]        thr_lat;
   logic                   et_lat;
   logic signed [BITa-1:0] acc;
   logic signed [BITa-1:0] new_acc;
   logic signed [BITa-1:0] neg_thr;
   logic signed [BITa-1:0] relu_acc;
   logic [IW-1:0]          idx;
   logic signed [BITi-1:0] d_elem;
   logic signed [BITi-1:0] w_elem;
   logic                   last;
   logic                   et_hit;

   assign d_elem   = d_lat[idx*BITi +: BITi];
   assign w_elem   = w_lat[idx*BITi +: BITi];
   assign neg_thr  = -$signed({1'b0, thr_lat});
   assign relu_acc = (new_acc > 0) ? new_acc : '0;
   assign last     = (idx == IW'(SIZE - 1));
   // The last-element rule wins over early termination, hence the gating by !last in the datapath.
   assign et_hit   = et_lat && (new_acc < neg_thr);

   mac_unit #(
      .BITi (BITi),
      .BITa (BITa)
   ) u_mac (
      .acc     (acc),
      .a       (d_elem),
      .b       (w_elem),
      .new_acc (new_acc)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (in_valid) next_state = MAC;
         MAC:     if (last || et_hit) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) ? ON : OFF;
      out_valid = (state == DONE) ? ON : OFF;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d_lat   <= '0;
         w_lat   <= '0;
         thr_lat <= '0;
         et_lat  <= OFF;
         acc     <= '0;
         idx     <= '0;
         q       <= '0;
         early   <= OFF;
         count   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  d_lat   <= d;
                  w_lat   <= w;
                  thr_lat <= threshold;
                  et_lat  <= et_en;
                  acc     <= '0;
                  idx     <= '0;
               end
            end
            MAC: begin
               acc <= new_acc;
               idx <= idx + 1'b1;
               if (last) begin
                  q     <= relu_acc;
                  early <= OFF;
                  count <= CW'(SIZE);
               end else if (et_hit) begin
                  q     <= relu_acc;
                  early <= ON;
                  count <= CW'(idx) + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
